// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one word-addressed
// memory port with a req/ready handshake; stops in HALT on an unsupported encoding.
module mips_multicycle_core #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              halted,
  output logic [31:0]       retired
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_N  = 32;
  localparam int unsigned RIDX_W = 5;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [DATA_W-1:0] ir, ir_nxt;
  logic [DATA_W-1:0] a, a_nxt;
  logic [DATA_W-1:0] b, b_nxt;
  logic [DATA_W-1:0] alu_out, alu_nxt;
  logic [DATA_W-1:0] mdr, mdr_nxt;
  logic [DATA_W-1:0] rf [REG_N];

  logic              rf_we;
  logic [RIDX_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              retire;

  logic [5:0]        op, funct;
  logic [RIDX_W-1:0] rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic [DATA_W-1:0] simm;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign imm   = ir[15:0];
  assign simm  = {{16{imm[15]}}, imm};

  logic              rtype_ok, op_ok, br_taken;
  logic [DATA_W-1:0] r_result;

  // R-type ALU and funct legality
  always_comb begin
    r_result = '0;
    rtype_ok = 1'b1;
    case (funct)
      FN_ADD:  r_result = a + b;
      FN_SUB:  r_result = a - b;
      FN_AND:  r_result = a & b;
      FN_OR:   r_result = a | b;
      FN_SLT:  r_result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      FN_SLL:  r_result = b << shamt;
      default: rtype_ok = 1'b0;
    endcase
  end

  always_comb begin
    op_ok = 1'b0;
    case (op)
      OP_RTYPE: op_ok = rtype_ok;
      OP_ADDI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: op_ok = 1'b1;
      default:  op_ok = 1'b0;
    endcase
  end

  // BNE inverts the equality test
  assign br_taken = (a == b) ^ (op == OP_BNE);

  // Next-state and datapath updates
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    a_nxt     = a;
    b_nxt     = b;
    alu_nxt   = alu_out;
    mdr_nxt   = mdr;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          ir_nxt    = mem_rdata;
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        a_nxt     = rf[rs];
        b_nxt     = rf[rt];
        state_nxt = op_ok ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        state_nxt = S_WB;
        case (op)
          OP_RTYPE: alu_nxt = r_result;
          OP_ADDI:  alu_nxt = a + simm;
          OP_LUI:   alu_nxt = {imm, 16'h0};
          OP_LW, OP_SW: begin
            alu_nxt   = a + simm;
            state_nxt = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            if (br_taken) pc_nxt = pc + ADDR_W'(simm);
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
          OP_J: begin
            pc_nxt    = ir[ADDR_W-1:0];
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
          default: state_nxt = S_HALT;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op == OP_SW) begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end else begin
            mdr_nxt   = mem_rdata;
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rf_waddr  = (op == OP_RTYPE) ? rd : rt;
        rf_wdata  = (op == OP_LW) ? mdr : alu_out;
        rf_we     = (rf_waddr != '0);
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // State, datapath and registered bus outputs (derived from next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= ADDR_W'(RESET_PC);
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
      retired   <= '0;
      halted    <= 1'b0;
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_W'(RESET_PC);
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ir        <= ir_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      alu_out   <= alu_nxt;
      mdr       <= mdr_nxt;
      if (rf_we) rf[rf_waddr] <= rf_wdata;
      if (retire) retired <= retired + 32'd1;
      halted    <= (state_nxt == S_HALT);
      mem_req   <= (state_nxt == S_FETCH) || (state_nxt == S_MEM);
      mem_we    <= (state_nxt == S_MEM) && (op == OP_SW);
      mem_addr  <= (state_nxt == S_MEM) ? alu_nxt[ADDR_W+1:2] : pc_nxt;
      mem_wdata <= b_nxt;
    end
  end

endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width of PC and memory bus; legal range 4..26.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_req  output  1  memory access request, held until accepted.
REQ-006 mem_we  output  1  write request; valid only with mem_req.
REQ-007 mem_addr  output  ADDR_W  word address.
REQ-008 mem_wdata  output  32  store data.
REQ-009 mem_ready  input  1  access completes on a rising edge where mem_req=1 and mem_ready=1.
REQ-010 mem_rdata  input  32  read data, valid in the accepting cycle.
REQ-011 halted  output  1  core stopped on an illegal opcode.
REQ-012 retired  output  32  count of completed instructions.

Function
REQ-013 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-014 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on accept, IR<=mem_rdata, PC<=PC+1, go to DECODE; otherwise stay in FETCH.
REQ-015 DECODE: latch A=R[rs] and B=R[rt]; go to EXEC; an opcode or funct outside REQ-016 goes to HALT.
REQ-016 Supported: R-type ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed), SLL 0x00 (rt<<shamt); ADDI 0x08, LUI 0x0F, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02.
REQ-017 Arithmetic SHALL be 32-bit two's complement, wrapping on overflow with no trap; ADDI uses sign-extended imm; LUI yields {imm,16'h0}.
REQ-018 EXEC, R-type/ADDI/LUI: ALUOut<=result, go to WB.
REQ-019 EXEC, LW/SW: ALUOut<=A+sext(imm), go to MEM.
REQ-020 EXEC, BEQ/BNE: if taken, PC<=PC+sext(imm), truncated to ADDR_W and wrapping modulo 2^ADDR_W; go to FETCH.
REQ-021 EXEC, J: PC<=IR[ADDR_W-1:0]; go to FETCH.
REQ-022 MEM: mem_req=1, mem_addr=ALUOut[ADDR_W+1:2] (byte address to word address), mem_we=1 for SW with mem_wdata=B; SW returns to FETCH on accept; LW latches MDR<=mem_rdata on accept and goes to WB.
REQ-023 WB: write rd for R-type, rt for ADDI/LUI/LW; go to FETCH.
REQ-024 Register 0 SHALL read as 0; writes to it are discarded.
REQ-025 retired SHALL increment by 1 on leaving WB, on leaving EXEC for branch/J, and on SW accept; it wraps at 2^32.
REQ-026 With mem_ready tied high, each instruction type SHALL take this many cycles: R-type/ADDI/LUI 4, LW 5, SW 4, BEQ/BNE/J 3.
REQ-027 Each cycle with mem_req=1 and mem_ready=0 SHALL add one stall cycle; mem_addr, mem_we and mem_wdata SHALL stay stable while stalled.
REQ-028 HALT: mem_req=0, halted=1; only rst leaves HALT.
REQ-029 mem_req SHALL be 0 in DECODE, EXEC, WB and HALT.

Reset
REQ-030 When rst=1 at a rising edge, the core SHALL set state=FETCH, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, all 32 registers=0, retired=0, halted=0.
REQ-031 Reset SHALL override any in-progress access; a transfer pending in FETCH or MEM is abandoned, and a pending SW SHALL NOT be re-issued after reset.
REQ-032 In the first cycle after reset, the core SHALL drive mem_req=1 and mem_addr=RESET_PC.

Verification
REQ-033 With mem_ready=1 and the program ADDI $1,$0,5; ADDI $2,$0,-3; ADD $3,$1,$2, the core SHALL give R3=2 and retired=3 after 12 cycles.
REQ-034 LUI $1,0x1234; ORI-free OR $2,$1,$0; SW $2,8($0); LW $4,8($0) SHALL give mem write addr=2 data=0x12340000 and R4=0x12340000.
REQ-035 BEQ $0,$0,-1 at PC=5 SHALL loop at PC 5; BNE $0,$0,+3 SHALL fall through to PC+1; each takes 3 cycles.
REQ-036 With mem_ready low for 3 cycles during LW, LW SHALL take 8 cycles and mem_addr SHALL stay constant during the stall.
REQ-037 Opcode 0x3F SHALL set halted=1 with mem_req=0 permanently; rst then SHALL restart the core from RESET_PC with retired=0.
REQ-038 ADDI $1,$0,0x7FFF then ADD repeated to overflow SHALL wrap without trap; ADDI $0,$0,9 SHALL leave R0=0.
